// File: rtl/q_update_engine_if.sv
// Update-request handshake for q_update_engine.
// Tuple, start pulse and busy/done status grouped together.
interface q_update_engine_if;
    logic               start;
    logic [5:0]         state;
    logic [1:0]         action;
    logic [5:0]         next_state;
    logic signed [15:0] next_reward;
    logic               next_terminal;
    logic               busy;
    logic               done;

    modport master (
        output start, state, action, next_state,
        output next_reward, next_terminal,
        input  busy, done
    );

    modport slave (
        input  start, state, action, next_state,
        input  next_reward, next_terminal,
        output busy, done
    );
endinterface

// File: rtl/q_update_engine.sv
// Temporal-difference update stage: Q(s,a) += alpha*(r + gamma*maxQ(s') - Q(s,a))
// over an internal 64x4 Q-table, with a registered query port.
module q_update_engine #(
    parameter int GAMMA       = 230,
    parameter int ALPHA_SHIFT = 2
) (
    input  logic               clk,
    input  logic               rst_n,
    q_update_engine_if.slave   upd,
    input  logic [5:0]         query_state,
    input  logic [1:0]         query_action,
    output logic signed [15:0] query_q
);

    localparam logic [2:0] IDLE  = 3'd0;
    localparam logic [2:0] LOAD  = 3'd1;
    localparam logic [2:0] SCAN  = 3'd2;
    localparam logic [2:0] CALC  = 3'd3;
    localparam logic [2:0] WRITE = 3'd4;

    localparam logic [7:0] GAMMA_U = 8'(GAMMA);

    logic [2:0]         fsm;
    logic [5:0]         s_r;
    logic [5:0]         ns_r;
    logic [1:0]         a_r;
    logic [1:0]         k;
    logic               term_r;
    logic signed [15:0] r_r;
    logic signed [15:0] q_sa;
    logic signed [15:0] max_q;
    logic signed [15:0] new_q;
    logic signed [15:0] scan_q;

    logic signed [15:0] q_tab [256];

    logic signed [15:0] m;
    logic signed [24:0] p;
    logic signed [24:0] disc;
    logic signed [17:0] target;
    logic signed [17:0] td;
    logic signed [17:0] delta;
    logic signed [17:0] sum;
    logic signed [15:0] sat_q;

    assign upd.busy = (fsm != IDLE);
    assign upd.done = (fsm == WRITE);
    assign scan_q   = q_tab[{ns_r, k}];

    // TD arithmetic on the latched tuple; result registered in CALC
    always_comb begin
        m      = term_r ? 16'sd0 : max_q;
        p      = $signed({17'd0, GAMMA_U}) * $signed({{9{m[15]}}, m});
        disc   = p >>> 8;
        target = $signed({{2{r_r[15]}}, r_r}) + $signed(disc[17:0]);
        td     = target - $signed({{2{q_sa[15]}}, q_sa});
        delta  = td >>> ALPHA_SHIFT;
        sum    = $signed({{2{q_sa[15]}}, q_sa}) + delta;
        if (sum > 18'sd32767)
            sat_q = 16'sh7FFF;
        else if (sum < -18'sd32768)
            sat_q = 16'sh8000;
        else
            sat_q = sum[15:0];
    end

    // Control FSM: latch tuple, read q_sa, scan s' for max, compute
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fsm    <= IDLE;
            s_r    <= '0;
            ns_r   <= '0;
            a_r    <= '0;
            k      <= '0;
            term_r <= 1'b0;
            r_r    <= '0;
            q_sa   <= '0;
            max_q  <= '0;
            new_q  <= '0;
        end else begin
            unique case (fsm)
                IDLE: begin
                    if (upd.start) begin
                        s_r    <= upd.state;
                        a_r    <= upd.action;
                        ns_r   <= upd.next_state;
                        r_r    <= upd.next_reward;
                        term_r <= upd.next_terminal;
                        fsm    <= LOAD;
                    end
                end
                LOAD: begin
                    q_sa  <= q_tab[{s_r, a_r}];
                    max_q <= q_tab[{ns_r, 2'd0}];
                    k     <= 2'd1;
                    fsm   <= SCAN;
                end
                SCAN: begin
                    // strict compare keeps the lower action on ties
                    if (scan_q > max_q)
                        max_q <= scan_q;
                    k <= k + 2'd1;
                    if (k == 2'd3)
                        fsm <= CALC;
                end
                CALC: begin
                    new_q <= sat_q;
                    fsm   <= WRITE;
                end
                WRITE: begin
                    fsm <= IDLE;
                end
                default: begin
                    fsm <= IDLE;
                end
            endcase
        end
    end

    // Q-table storage; the only write path is the WRITE state
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++)
                q_tab[i] <= '0;
        end else if (fsm == WRITE) begin
            q_tab[{s_r, a_r}] <= new_q;
        end
    end

    // Registered query port; sees the old value during WRITE
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            query_q <= '0;
        else
            query_q <= q_tab[{query_state, query_action}];
    end

endmodule

// File: tb/tb_q_update_engine.sv
// Directed bench for q_update_engine: vector table plus
// hand sequences for ignored starts and mid-update reset.
module tb_q_update_engine;

    logic               clk = 1'b0;
    logic               rst_n = 1'b0;
    logic [5:0]         qs = '0;
    logic [1:0]         qa = '0;
    logic signed [15:0] qq0;
    logic signed [15:0] qq1;

    q_update_engine_if u0 ();
    q_update_engine_if u1 ();

    q_update_engine #(.GAMMA(230), .ALPHA_SHIFT(2)) dut (
        .clk(clk), .rst_n(rst_n), .upd(u0),
        .query_state(qs), .query_action(qa), .query_q(qq0)
    );

    q_update_engine #(.GAMMA(230), .ALPHA_SHIFT(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .upd(u1),
        .query_state(qs), .query_action(qa), .query_q(qq1)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit                 sel;
        logic [5:0]         s;
        logic [1:0]         a;
        logic [5:0]         ns;
        logic signed [15:0] r;
        logic               t;
        logic signed [15:0] exp;
    } vec_t;

    vec_t vecs[14];
    int   mdl[2][256];
    int   checks = 0;
    int   errors = 0;
    bit   sel = 1'b0;

    logic               busy_m;
    logic               done_m;
    logic signed [15:0] qq_m;

    always_comb begin
        busy_m = sel ? u1.busy : u0.busy;
        done_m = sel ? u1.done : u0.done;
        qq_m   = sel ? qq1 : qq0;
    end

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    task automatic drive(input bit which, input logic st,
                         input logic [5:0] s, input logic [1:0] a,
                         input logic [5:0] ns,
                         input logic signed [15:0] r, input logic t);
        if (which) begin
            u1.start = st; u1.state = s; u1.action = a;
            u1.next_state = ns; u1.next_reward = r; u1.next_terminal = t;
        end else begin
            u0.start = st; u0.state = s; u0.action = a;
            u0.next_state = ns; u0.next_reward = r; u0.next_terminal = t;
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int  n;
        bit  got;
        int  key;
        key = {v.s, v.a};
        sel = v.sel;
        qs  = v.s;
        qa  = v.a;
        drive(v.sel, 1'b1, v.s, v.a, v.ns, v.r, v.t);
        @(posedge clk); #1;
        drive(v.sel, 1'b0, v.s, v.a, v.ns, v.r, v.t);
        chk($sformatf("v%0d busy_after_start", idx), int'(busy_m), 1);
        n = 0;
        got = 1'b0;
        while (n < 20 && !got) begin
            @(posedge clk); #1;
            n++;
            if (done_m) got = 1'b1;
        end
        chk($sformatf("v%0d done_seen", idx), int'(got), 1);
        chk($sformatf("v%0d done_latency", idx), n, 5);
        @(posedge clk); #1;
        chk($sformatf("v%0d query_old", idx), int'(qq_m), mdl[v.sel][key]);
        chk($sformatf("v%0d done_pulse", idx), int'(done_m), 0);
        chk($sformatf("v%0d busy_clear", idx), int'(busy_m), 0);
        @(posedge clk); #1;
        chk($sformatf("v%0d query_new", idx), int'(qq_m), int'(v.exp));
        mdl[v.sel][key] = int'(v.exp);
    endtask

    task automatic query(input string nm, input bit which,
                         input logic [5:0] s, input logic [1:0] a,
                         input int exp);
        sel = which;
        qs  = s;
        qa  = a;
        @(posedge clk); #1;
        chk(nm, int'(qq_m), exp);
    endtask

    initial begin
        int  n;
        int  dones;
        bit  got;

        vecs[0]  = '{0, 6'd24, 2'd1, 6'd25,  16'sd100,   1'b1,  16'sd25};
        vecs[1]  = '{0, 6'd23, 2'd1, 6'd24,  16'sd0,     1'b0,  16'sd5};
        vecs[2]  = '{0, 6'd2,  2'd1, 6'd3,  -16'sd46,    1'b0, -16'sd12};
        vecs[3]  = '{0, 6'd5,  2'd0, 6'd63,  16'sd40,    1'b1,  16'sd10};
        vecs[4]  = '{0, 6'd5,  2'd2, 6'd63,  16'sd40,    1'b1,  16'sd10};
        vecs[5]  = '{0, 6'd10, 2'd3, 6'd5,   16'sd0,     1'b0,  16'sd2};
        vecs[6]  = '{0, 6'd24, 2'd1, 6'd24,  16'sd100,   1'b0,  16'sd49};
        vecs[7]  = '{0, 6'd30, 2'd0, 6'd31, -16'sd32768, 1'b1, -16'sd8192};
        vecs[8]  = '{0, 6'd30, 2'd0, 6'd31, -16'sd32768, 1'b1, -16'sd14336};
        vecs[9]  = '{1, 6'd0,  2'd0, 6'd0,   16'sd32767, 1'b0,  16'sd32767};
        vecs[10] = '{1, 6'd0,  2'd0, 6'd0,   16'sd32767, 1'b0,  16'sd32767};
        vecs[11] = '{1, 6'd0,  2'd0, 6'd0,   16'sd32767, 1'b0,  16'sd32767};
        vecs[12] = '{1, 6'd1,  2'd0, 6'd1,  -16'sd32768, 1'b1, -16'sd32768};
        vecs[13] = '{1, 6'd1,  2'd0, 6'd1,  -16'sd32768, 1'b1, -16'sd32768};

        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 256; i++)
                mdl[d][i] = 0;

        drive(1'b0, 1'b0, '0, '0, '0, '0, 1'b0);
        drive(1'b1, 1'b0, '0, '0, '0, '0, 1'b0);

        repeat (3) @(posedge clk);
        #1;
        chk("reset busy", int'(u0.busy), 0);
        chk("reset done", int'(u0.done), 0);
        chk("reset query_q", int'(qq0), 0);
        rst_n = 1'b1;

        for (int i = 0; i < 256; i++) begin
            qs = 6'(i >> 2);
            qa = 2'(i);
            @(posedge clk); #1;
            chk($sformatf("reset entry %0d", i), int'(qq0), 0);
            chk($sformatf("reset entry0 %0d", i), int'(qq1), 0);
        end

        for (int i = 0; i < 14; i++)
            run_vec(vecs[i], i);

        sel = 1'b0;
        qs  = 6'd40;
        qa  = 2'd0;
        drive(1'b0, 1'b1, 6'd40, 2'd0, 6'd41, 16'sd80, 1'b1);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 6'd40, 2'd0, 6'd41, 16'sd80, 1'b1);
        @(posedge clk); #1;
        drive(1'b0, 1'b1, 6'd41, 2'd1, 6'd42, 16'sd400, 1'b1);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 6'd41, 2'd1, 6'd42, 16'sd400, 1'b1);
        n = 0;
        got = 1'b0;
        while (n < 20 && !got) begin
            @(posedge clk); #1;
            n++;
            if (u0.done) got = 1'b1;
        end
        chk("busy_ign done_seen", int'(got), 1);
        drive(1'b0, 1'b1, 6'd42, 2'd2, 6'd43, 16'sd400, 1'b1);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 6'd42, 2'd2, 6'd43, 16'sd400, 1'b1);
        chk("write_ign busy", int'(u0.busy), 0);
        dones = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (u0.done) dones++;
        end
        chk("ign extra dones", dones, 0);
        query("ign Q40_0", 1'b0, 6'd40, 2'd0, 20);
        query("ign Q41_1", 1'b0, 6'd41, 2'd1, 0);
        query("ign Q42_2", 1'b0, 6'd42, 2'd2, 0);
        query("tie Q10_3", 1'b0, 6'd10, 2'd3, 2);

        qs = 6'd24;
        qa = 2'd1;
        drive(1'b0, 1'b1, 6'd50, 2'd0, 6'd24, 16'sd100, 1'b0);
        @(posedge clk); #1;
        drive(1'b0, 1'b0, 6'd50, 2'd0, 6'd24, 16'sd100, 1'b0);
        @(posedge clk);
        @(posedge clk); #1;
        chk("pre_rst busy", int'(u0.busy), 1);
        chk("pre_rst query", int'(qq0), 49);
        rst_n = 1'b0;
        #1;
        chk("mid_rst busy", int'(u0.busy), 0);
        chk("mid_rst done", int'(u0.done), 0);
        chk("mid_rst query", int'(qq0), 0);
        chk("mid_rst query0", int'(qq1), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        for (int d = 0; d < 2; d++)
            for (int i = 0; i < 256; i++)
                mdl[d][i] = 0;
        query("rst Q24_1", 1'b0, 6'd24, 2'd1, 0);
        query("rst Q23_1", 1'b0, 6'd23, 2'd1, 0);
        query("rst Q5_0", 1'b0, 6'd5, 2'd0, 0);
        query("rst Q50_0", 1'b0, 6'd50, 2'd0, 0);
        query("rst Q40_0", 1'b0, 6'd40, 2'd0, 0);
        query("rst dut0 Q0_0", 1'b1, 6'd0, 2'd0, 0);
        query("rst dut0 Q1_0", 1'b1, 6'd1, 2'd0, 0);
        dones = 0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            if (u0.done) dones++;
        end
        chk("rst no done", dones, 0);
        run_vec(vecs[0], 100);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/q_update_engine.md
# q_update_engine

Temporal-difference update stage for the maze Q-learning datapath. It sits directly downstream of the reward generator and the state-transition logic. It consumes one transition tuple (state, action, next_state, next_reward, next_terminal) per start pulse and reads the 4 Q-values of next_state to find their maximum. It then applies Q(s,a) += alpha*(r + gamma*maxQ(s') − Q(s,a)) to an internal 64×4 Q-table and exposes a registered query port for the action selector.

## Interface

Parameters:
- GAMMA, 230: discount, unsigned 8-bit, value/256 (230 ≈ 0.9)
- ALPHA_SHIFT, 2: learning rate = 2^−ALPHA_SHIFT, range 0..7

Ports:
- clk  in  1  single clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle request; tuple inputs sampled on the same edge
- state  in  6  current state s
- action  in  2  action a taken in s
- next_state  in  6  resulting state s'
- next_reward  in  16  signed reward r (reward generator output)
- next_terminal  in  1  s' is terminal; maxQ(s') forced to 0
- busy  out  1  update in progress
- done  out  1  one-cycle pulse, the Q-table write occurs on this cycle's closing edge
- query_state  in  6  read address, state
- query_action  in  2  read address, action
- query_q  out  16  signed Q[query_state][query_action], registered

## Operation

- Storage: 256 entries of signed 16 bits, indexed {state, action}. All entries are 0 after reset. There is no other write path.
- FSM states and transitions:
  - IDLE: on start with busy=0, latch the tuple and go to LOAD.
  - LOAD: q_sa ← Q[s][a]; max ← Q[s'][0]; k ← 1.
  - SCAN: 3 cycles, k = 1..3. Set max ← Q[s'][k] when it is strictly greater than max, so ties keep the lower action.
  - CALC: compute new_q and register it.
  - WRITE: Q[s][a] ← new_q; done=1; return to IDLE.
- start while busy=1 is ignored, with no queuing. start in the same cycle as done (WRITE) is also ignored.
- Tuple inputs are don't-care except on an accepted start edge.
- Arithmetic:
  - m = next_terminal ? 0 : max.
  - p = GAMMA × m, 25-bit signed; disc = p >>> 8 (arithmetic shift, floor).
  - target = r + disc, 18-bit signed.
  - td = target − q_sa, 18-bit signed.
  - delta = td >>> ALPHA_SHIFT (floor).
  - sum = q_sa + delta, 18-bit signed.
  - new_q = sum saturated to [−32768, 32767].
- Self-loop (s' == s): SCAN reads the pre-update value of Q[s][a].
- Query port: query_q ← Q[query_state][query_action] on every edge, so latency is 1 cycle. When the query addresses the entry being written in WRITE, query_q returns the old value; the new value appears on the next cycle.

## Timing

- Reset values: busy=0, done=0, query_q=0, FSM=IDLE, Q-table all 0.
- start sampled at edge E0:
  - busy=1 from after E0 through the WRITE cycle, i.e. 6 cycles (LOAD, SCAN×3, CALC, WRITE).
  - done=1 only in the WRITE cycle, the 6th cycle after E0.
  - The new value is visible via query_q 2 cycles after done.
- Throughput: one update per 7 cycles at most. start is next accepted the cycle after done.
- Reset asserted mid-update: the FSM aborts immediately, no partial write persists, and the entire table clears to 0.

## Test plan

- Reset, then query every {s,a} -> query_q=0 for all 256 entries; busy=0, done=0.
- start s=24, a=1, s'=25, r=100, terminal=1 -> done exactly 6 cycles after start; Q[24][1]=25.
- Next: s=23, a=1, s'=24, r=0, terminal=0 -> maxQ=25, disc=5750>>>8=22, td=22, delta=5; Q[23][1]=5.
- From reset: s=2, a=1, s'=3, r=16'hFFD2 (−46), terminal=0 -> td=−46, delta=−12 (floor); Q[2][1]=−12 (16'hFFF4).
- Saturation: repeat s=0, a=0, s'=0, r=32767, terminal=0 with ALPHA_SHIFT=0 -> Q[0][0] reaches 32767 and holds; never wraps negative.
- Tie and ignore: set Q[5][0]=Q[5][2] as equal maxima (via prior updates). Pulse start during busy -> ignored, no second done. Then assert rst_n low mid-SCAN -> busy=0 immediately and all queried entries read 0.
